// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM stream reader: FSM encoding, word geometry
// and the byte-reversal helper used when BRAM_RD_BYTESWAP_EN is defined.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_STEP  = 4;

    // Reverse byte order of a 32-bit word.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on dout
// whenever empty=0; push while full and pop while empty are ignored.
module bram_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Advance a pointer with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array: written on push only.
    // NOTE: the data array is deliberately not reset; validity is tracked by
    // count and the pointers, and a reset-free array maps onto plain RAM/regs.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Port-B read master: on start, reads len consecutive 32-bit words from a
// byte base address (wrapping modulo MEM_BYTES), hides the BRAM read latency
// and emits the words as a valid/ready stream with tlast, buffered by a
// small FIFO. Optional macro BRAM_RD_BYTESWAP_EN byte-reverses each word.
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int MEM_BYTES    = 8192,
    parameter int LEN_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             bram_clk,
    output logic             bram_rst,
    output logic             bram_en,
    output logic [3:0]       bram_we,
    output logic [31:0]      bram_din,
    output logic [31:0]      bram_addr,
    input  logic [31:0]      bram_dout,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t                    state;
    state_t                    state_next;
    logic [31:0]               addr;
    logic [LEN_W-1:0]          remaining;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          beat_cnt;
    logic [READ_LATENCY-1:0]   rd_vld;
    logic [31:0]               inflight;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [31:0]               fifo_din;
    logic [31:0]               fifo_dout;
    logic                      accept;
    logic                      issue;
    logic                      pop;
    logic                      fin;

    assign bram_clk = clk;
    assign bram_rst = rst;
    assign bram_we  = 4'h0;
    assign bram_din = 32'h0;

    // A start coinciding with the done pulse belongs to the finished transfer.
    assign accept = (state == IDLE) && start && !done;

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_empty ? 32'h0 : fifo_dout;
    assign pop      = m_tvalid && m_tready;
    assign m_tlast  = m_tvalid && (beat_cnt == (len_q - LEN_W'(1)));
    assign fin      = (state == DRAIN) && (inflight == 32'h0) && pop && m_tlast;

`ifdef BRAM_RD_BYTESWAP_EN
    assign fifo_din = byte_swap(bram_dout);
`else
    assign fifo_din = bram_dout;
`endif

    // Reads issued but not yet in the FIFO: the registered enable plus the
    // latency pipeline.
    // NOTE: every variable written in always_comb gets a default at the top,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        inflight = {31'b0, bram_en};
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + {31'b0, rd_vld[i]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept && (len != '0))                 state_next = RUN;
            RUN:     if (issue && (remaining == LEN_W'(1)))     state_next = DRAIN;
            DRAIN:   if (fin)                                   state_next = IDLE;
            default:                                            state_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the credit-gated read issue decision.
    always_comb begin
        busy  = (state != IDLE);
        issue = (state == RUN) && (remaining != '0) && !fifo_full &&
                ((32'(fifo_count) + inflight) < 32'(FIFO_DEPTH));
    end

    // Transfer datapath: address/count tracking, registered BRAM request,
    // beat counter for tlast and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            bram_en   <= 1'b0;
            bram_addr <= 32'h0;
            addr      <= 32'h0;
            remaining <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
        end else begin
            done    <= fin || (accept && (len == '0));
            bram_en <= issue;
            if (accept) begin
                addr      <= base_addr & ~32'(WORD_BYTES - 1);
                remaining <= len;
                len_q     <= len;
            end else if (issue) begin
                bram_addr <= addr;
                addr      <= (addr + 32'(ADDR_STEP)) & 32'(MEM_BYTES - 1);
                remaining <= remaining - LEN_W'(1);
            end
            if (accept)   beat_cnt <= '0;
            else if (pop) beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    // Read-latency valid pipeline; the tail marks bram_dout as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= bram_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
        end
    end

    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_vld[READ_LATENCY-1]),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: directed transfers push expected
// beats into a queue; a negedge monitor pops and compares every handshake.
module tb_bram_stream_reader;

    localparam int LEN_W     = 16;
    localparam int MEM_BYTES = 8192;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] len;
    logic             busy, done, bram_clk, bram_rst, bram_en;
    logic [3:0]       bram_we;
    logic [31:0]      bram_din, bram_addr;
    logic [31:0]      bram_dout = 32'h0;
    logic [31:0]      m_tdata;
    logic             m_tvalid, m_tready, m_tlast;

    logic [31:0] mem [MEM_BYTES/4];
    beat_t       sb[$];
    logic [31:0] addr_q[$];
    logic [31:0] t4_addr [4] = '{32'd8184, 32'd8188, 32'd0, 32'd4};

    int checks = 0, failures = 0;
    int beats_seen = 0, out_cnt = 0, max_out = 0, ready_ph = 0;
    bit ready_toggle = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;

    int first_en, en_cnt, last_en, first_v, done_cyc, done_cnt, busy_at_done, busy_cnt;

    bram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .bram_clk(bram_clk), .bram_rst(bram_rst),
        .bram_en(bram_en), .bram_we(bram_we), .bram_din(bram_din),
        .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    // Port-B model of the dual-port RAM, one cycle read latency.
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[12:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef BRAM_RD_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Monitor: stability under backpressure, scoreboard compare, occupancy.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
            out_cnt    = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", m_tdata, prev_data);
            end
            if (bram_en) out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
            if (m_tvalid && m_tready) begin
                beats_seen++;
                out_cnt--;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_tdata, e.data);
                    check("beat_last", 32'(m_tlast), 32'(e.last));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    // Ready driver: constant 1, or the 1,0,0 pattern while ready_toggle is set.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) begin
                m_tready = (ready_ph == 0);
                ready_ph = (ready_ph + 1) % 3;
            end else begin
                m_tready = 1'b1;
                ready_ph = 0;
            end
        end
    end

    task automatic push_range(input logic [31:0] b, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = ((b & 32'hFFFF_FFFC) + 32'(4 * i)) & 32'(MEM_BYTES - 1);
            sb.push_back('{data: exp_word(mem[a[12:2]]), last: (i == n - 1)});
        end
    endtask

    task automatic do_start(input logic [31:0] b, input int n);
        base_addr = b;
        len       = n[LEN_W-1:0];
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observe from the cycle after start was sampled (cyc 0) until 2 cycles
    // past done; optionally inject a second start at negedge inj_cyc.
    task automatic measure(input int inj_cyc, input int inj_len);
        int  cyc  = 0;
        int  tail = 0;
        bit  seen = 1'b0;
        first_en = -1; en_cnt = 0; last_en = -1; first_v = -1;
        done_cyc = -1; done_cnt = 0; busy_at_done = -1; busy_cnt = 0;
        addr_q.delete();
        while (tail < 3) begin
            @(negedge clk);
            if (bram_en) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
                addr_q.push_back(bram_addr);
            end
            if (m_tvalid && first_v < 0) first_v = cyc;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (!seen) begin
                    done_cyc     = cyc;
                    busy_at_done = int'(busy);
                end
                seen = 1'b1;
            end
            if (cyc == inj_cyc) begin
                start = 1'b1; base_addr = 32'h0; len = inj_len[LEN_W-1:0];
            end else if (cyc == inj_cyc + 1) begin
                start = 1'b0;
            end
            if (seen) tail++;
            cyc++;
            if (cyc > 300) begin
                checks++;
                failures++;
                $display("FAIL timeout: no done within 300 cycles, got none expected one");
                tail = 3;
            end
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_bram_en"}, 32'(bram_en), 32'd0);
        check({pfx, "_bram_addr"}, bram_addr, 32'd0);
        check({pfx, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({pfx, "_tlast"}, 32'(m_tlast), 32'd0);
        check({pfx, "_tdata"}, m_tdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int w;
        rst = 1'b1; start = 1'b0; base_addr = 32'h0; len = '0;
        for (int j = 0; j < MEM_BYTES / 4; j++) mem[j] = 32'(j * 4);
        mem[16] = 32'h1122_3344;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_bram_we", 32'(bram_we), 32'd0);
        check("reset_bram_din", bram_din, 32'd0);
        check("reset_bram_rst", 32'(bram_rst), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: base 0, len 8, full throughput.
        push_range(32'd0, 8);
        do_start(32'd0, 8);
        measure(-10, 0);
        check("t1_first_en", first_en, 1);
        check("t1_en_cnt", en_cnt, 8);
        check("t1_en_span", last_en - first_en, 7);
        check("t1_first_valid", first_v, 3);
        check("t1_done_cyc", done_cyc, 11);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_busy_cnt", busy_cnt, 11);
        check("t1_sb_empty", sb.size(), 0);

        // 2: same transfer with ready pattern 1,0,0.
        max_out = 0;
        ready_toggle = 1'b1;
        push_range(32'd0, 8);
        do_start(32'd0, 8);
        measure(-10, 0);
        ready_toggle = 1'b0;
        check("t2_en_cnt", en_cnt, 8);
        check("t2_max_outstanding", max_out, 4);
        check("t2_en_stalled", 32'(last_en - first_en > 7), 32'd1);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_sb_empty", sb.size(), 0);

        // 3: len 0.
        do_start(32'd0, 0);
        measure(-10, 0);
        check("t3_done_cyc", done_cyc, 0);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_en_cnt", en_cnt, 0);
        check("t3_first_valid", first_v, -1);
        check("t3_busy_cnt", busy_cnt, 0);

        // 4: address wrap.
        push_range(32'd8184, 4);
        do_start(32'd8184, 4);
        measure(-10, 0);
        check("t4_en_cnt", en_cnt, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF, t4_addr[i]);
        check("t4_sb_empty", sb.size(), 0);

        // 5: reset after 3 beats, then a fresh short transfer.
        push_range(32'd0, 8);
        b0 = beats_seen;
        do_start(32'd0, 8);
        w = 0;
        while (beats_seen < b0 + 3 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("t5_three_beats", 32'(beats_seen - b0 >= 3), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("t5_after_rst");
        push_range(32'd16, 2);
        do_start(32'd16, 2);
        measure(-10, 0);
        check("t5_en_cnt", en_cnt, 2);
        check("t5_sb_empty", sb.size(), 0);

        // 6: start while busy is ignored; byte order of a distinctive word.
`ifdef BRAM_RD_BYTESWAP_EN
        sb.push_back('{data: 32'h4433_2211, last: 1'b0});
        sb.push_back('{data: 32'h4400_0000, last: 1'b0});
        sb.push_back('{data: 32'h4800_0000, last: 1'b0});
        sb.push_back('{data: 32'h4C00_0000, last: 1'b1});
`else
        sb.push_back('{data: 32'h1122_3344, last: 1'b0});
        sb.push_back('{data: 32'd68, last: 1'b0});
        sb.push_back('{data: 32'd72, last: 1'b0});
        sb.push_back('{data: 32'd76, last: 1'b1});
`endif
        do_start(32'd64, 4);
        measure(2, 1);
        check("t6_en_cnt", en_cnt, 4);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_sb_empty", sb.size(), 0);

        // 7: start in the same cycle as done is ignored.
        do_start(32'd0, 0);
        measure(0, 2);
        check("t7_done_cyc", done_cyc, 0);
        check("t7_done_cnt", done_cnt, 1);
        check("t7_en_cnt", en_cnt, 0);
        check("t7_first_valid", first_v, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
